hd44780_responder: RTL and testbench

- Synthesizable HD44780-compatible display-side model: the device end of the 1602 character-LCD write bus the board drives.
- Samples `rs/rw/en/dat` from an LCD master and decodes the instruction set.
- Holds an 80-byte DDRAM with address counter and busy flag, and answers busy-flag/address and data reads.
- Exposes DDRAM through a second read port, so an on-chip scanner (e.g. VGA text overlay) or a bench can check what the master wrote.

---
 rtl/hd44780_pkg.sv | 82 ++++++++
 rtl/hd44780_responder_if.sv | 20 ++
 rtl/hd44780_ddram.sv | 33 +++
 rtl/hd44780_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_hd44780_responder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hd44780_pkg.sv
// Shared types, constants and address helpers for the HD44780 responder.
// The address helpers encode the one-line/two-line DDRAM layout.
package hd44780_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } state_t;

    typedef enum logic [3:0] {
        I_NOP,
        I_CLEAR,
        I_HOME,
        I_ENTRY,
        I_DISP,
        I_SHIFT,
        I_FUNC,
        I_CGRAM,
        I_DDRAM
    } instr_t;

    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam int         LINE_LEN    = 40;
    localparam int         DDRAM_DEPTH = 80;

    function automatic logic [6:0] idx(input logic [6:0] ac,
                                       input logic       two);
        if (two)
            return (ac[6] ? 7'(LINE_LEN) : 7'd0) + {1'b0, ac[5:0]};
        return ac;
    endfunction

    function automatic logic ac_valid(input logic [6:0] ac,
                                      input logic       two);
        if (two)
            return {1'b0, ac[5:0]} < 7'(LINE_LEN);
        return ac < 7'(DDRAM_DEPTH);
    endfunction

    // Out-of-range addresses snap back to the start of DDRAM.
    function automatic logic [6:0] ac_step(input logic [6:0] ac,
                                           input logic       two,
                                           input logic       inc);
        if (!ac_valid(ac, two))
            return LINE0_BASE;
        if (two) begin
            if (inc) begin
                if (ac == LINE0_BASE + 7'(LINE_LEN - 1))
                    return LINE1_BASE;
                if (ac == LINE1_BASE + 7'(LINE_LEN - 1))
                    return LINE0_BASE;
                return ac + 7'd1;
            end
            if (ac == LINE1_BASE)
                return LINE0_BASE + 7'(LINE_LEN - 1);
            if (ac == LINE0_BASE)
                return LINE1_BASE + 7'(LINE_LEN - 1);
            return ac - 7'd1;
        end
        if (inc)
            return (ac == 7'(DDRAM_DEPTH - 1)) ? LINE0_BASE : ac + 7'd1;
        return (ac == LINE0_BASE) ? 7'(DDRAM_DEPTH - 1) : ac - 7'd1;
    endfunction

    function automatic instr_t classify(input logic [7:0] d);
        priority case (1'b1)
            d[7]:    return I_DDRAM;
            d[6]:    return I_CGRAM;
            d[5]:    return I_FUNC;
            d[4]:    return I_SHIFT;
            d[3]:    return I_DISP;
            d[2]:    return I_ENTRY;
            d[1]:    return I_HOME;
            d[0]:    return I_CLEAR;
            default: return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/hd44780_responder_if.sv
// LCD master bus: the 1602 write/read strobe interface.
// The master drives rs/rw/en/din; the display answers on dout/doe.
interface hd44780_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_din;
    logic [7:0] lcd_dout;
    logic       lcd_doe;

    modport master (
        output lcd_rs, lcd_rw, lcd_en, lcd_din,
        input  lcd_dout, lcd_doe
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_en, lcd_din,
        output lcd_dout, lcd_doe
    );
endinterface

// File: rtl/hd44780_ddram.sv
// 80x8 display RAM: one write/async-read port for the bus side and a
// registered read port for a scanner; same-cycle collisions return old data.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] baddr,
    output logic [7:0] bdata,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && waddr < 7'(DDRAM_DEPTH))
            mem[waddr] <= wdata;
    end

    assign bdata = (baddr < 7'(DDRAM_DEPTH)) ? mem[baddr] : SPACE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_addr < 7'(DDRAM_DEPTH))
            rd_data <= mem[rd_addr];
        else
            rd_data <= SPACE;
    end
endmodule

// File: rtl/hd44780_responder.sv
// HD44780-compatible display side: synchronizes the LCD bus, decodes the
// instruction set, keeps DDRAM, address counter and busy flag.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int BUSY_CYC  = 1850,
    parameter int CLEAR_CYC = 76000
) (
    input  logic                      clk,
    input  logic                      rst,
    hd44780_responder_if.slave        bus,
    input  logic [6:0]                rd_addr,
    output logic [7:0]                rd_data,
    output logic                      disp_on,
    output logic                      cursor_on,
    output logic                      blink_on,
    output logic                      two_line,
    output logic                      busy,
    output logic                      overrun
);
    logic       en_s1, en_s2, en_d;
    logic       rs_s1, rs_s2, rs_d;
    logic       rw_s1, rw_s2, rw_d;
    logic [7:0] din_s1, din_s2, din_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {en_s1, en_s2, en_d} <= '0;
            {rs_s1, rs_s2, rs_d} <= '0;
            {rw_s1, rw_s2, rw_d} <= '0;
            din_s1 <= '0;
            din_s2 <= '0;
            din_d  <= '0;
        end else begin
            en_s1  <= bus.lcd_en;
            en_s2  <= en_s1;
            en_d   <= en_s2;
            rs_s1  <= bus.lcd_rs;
            rs_s2  <= rs_s1;
            rs_d   <= rs_s2;
            rw_s1  <= bus.lcd_rw;
            rw_s2  <= rw_s1;
            rw_d   <= rw_s2;
            din_s1 <= bus.lcd_din;
            din_s2 <= din_s1;
            din_d  <= din_s2;
        end
    end

    logic rise, fall, wr, rd;
    assign rise = en_s2 & ~en_d;
    assign fall = ~en_s2 & en_d;
    assign wr   = fall & ~rw_d;
    assign rd   = fall & rw_d;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [6:0]  fill, fill_n;
    logic [6:0]  ac, ac_n;
    logic        id, id_n, cg, cg_n;
    logic        two_n, disp_n, cur_n, blink_n, ovr_n;
    logic        go_exec, go_long, go_clear;
    logic        bus_we, fill_we, we;
    logic [6:0]  waddr, bidx;
    logic [7:0]  wdata, bdata, rd_val;
    logic        in_rng;
    instr_t      cls;

    assign busy   = (state != IDLE);
    assign bidx   = idx(ac, two_line);
    assign in_rng = ac_valid(ac, two_line);
    assign cls    = classify(din_d);
    assign rd_val = in_rng ? bdata : SPACE;

    assign we    = fill_we | bus_we;
    assign waddr = fill_we ? fill : bidx;
    assign wdata = fill_we ? SPACE : din_d;

    hd44780_ddram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .baddr   (bidx),
        .bdata   (bdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        ac_n     = ac;
        id_n     = id;
        cg_n     = cg;
        ovr_n    = overrun;
        two_n    = two_line;
        disp_n   = disp_on;
        cur_n    = cursor_on;
        blink_n  = blink_on;
        bus_we   = 1'b0;
        go_exec  = 1'b0;
        go_long  = 1'b0;
        go_clear = 1'b0;
        if (wr && busy) begin
            ovr_n = 1'b1;
        end else if (wr && rs_d) begin
            go_exec = 1'b1;
            // CGRAM-mode data has nowhere to go
            if (!cg) begin
                bus_we = in_rng;
                ac_n   = ac_step(ac, two_line, id);
            end
        end else if (wr) begin
            unique case (cls)
                I_NOP: ;
                I_CLEAR: begin
                    go_clear = 1'b1;
                    ac_n     = LINE0_BASE;
                    id_n     = 1'b1;
                end
                I_HOME: begin
                    go_long = 1'b1;
                    ac_n    = LINE0_BASE;
                end
                I_ENTRY: begin
                    go_exec = 1'b1;
                    id_n    = din_d[1];
                end
                I_DISP: begin
                    go_exec = 1'b1;
                    disp_n  = din_d[2];
                    cur_n   = din_d[1];
                    blink_n = din_d[0];
                end
                I_SHIFT: begin
                    go_exec = 1'b1;
                    if (!din_d[3])
                        ac_n = ac_step(ac, two_line, din_d[2]);
                end
                I_FUNC: begin
                    go_exec = 1'b1;
                    two_n   = din_d[3];
                end
                I_CGRAM: begin
                    go_exec = 1'b1;
                    cg_n    = 1'b1;
                end
                I_DDRAM: begin
                    go_exec = 1'b1;
                    cg_n    = 1'b0;
                    ac_n    = din_d[6:0];
                end
                default: ;
            endcase
        end else if (rd && rs_d) begin
            go_exec = 1'b1;
            ac_n    = ac_step(ac, two_line, id);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fill_n  = fill;
        fill_we = 1'b0;
        unique case (state)
            IDLE: begin
                if (go_clear) begin
                    state_n = CLEAR;
                    cnt_n   = 32'(CLEAR_CYC);
                    fill_n  = '0;
                end else if (go_long) begin
                    state_n = EXEC;
                    cnt_n   = 32'(CLEAR_CYC);
                end else if (go_exec) begin
                    state_n = EXEC;
                    cnt_n   = 32'(BUSY_CYC);
                end
            end
            EXEC: begin
                cnt_n = cnt - 32'd1;
                if (cnt <= 32'd1)
                    state_n = IDLE;
            end
            CLEAR: begin
                cnt_n = cnt - 32'd1;
                if (fill < 7'(DDRAM_DEPTH)) begin
                    fill_we = 1'b1;
                    fill_n  = fill + 7'd1;
                end
                if (cnt <= 32'd1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset lands in CLEAR so the power-on fill runs without a command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= 32'(CLEAR_CYC);
            fill      <= '0;
            ac        <= LINE0_BASE;
            id        <= 1'b1;
            cg        <= 1'b0;
            two_line  <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fill      <= fill_n;
            ac        <= ac_n;
            id        <= id_n;
            cg        <= cg_n;
            two_line  <= two_n;
            disp_on   <= disp_n;
            cursor_on <= cur_n;
            blink_on  <= blink_n;
            overrun   <= ovr_n;
        end
    end

    logic       doe_q, rd_rs;
    logic [7:0] dout_q;

    assign bus.lcd_doe  = doe_q;
    assign bus.lcd_dout = dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            doe_q  <= 1'b0;
            dout_q <= '0;
            rd_rs  <= 1'b0;
        end else if (rise) begin
            doe_q  <= rw_s2;
            rd_rs  <= rs_s2;
            dout_q <= rs_s2 ? rd_val : {busy, ac};
        end else if (fall) begin
            doe_q <= 1'b0;
        end else if (doe_q) begin
            dout_q <= rd_rs ? rd_val : {busy, ac};
        end
    end
endmodule

// File: tb/tb_hd44780_responder.sv
// Bench for hd44780_responder: directed and randomized LCD bus traffic
// checked against a position-based model of the display RAM and AC.
module tb_hd44780_responder;
    localparam int BUSY_CYC  = 20;
    localparam int CLEAR_CYC = 200;
    localparam int LIMIT     = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       disp_on, cursor_on, blink_on, two_line, busy, overrun;

    hd44780_responder_if bif ();

    hd44780_responder #(
        .BUSY_CYC  (BUSY_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .two_line  (two_line),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_mem [80];
    logic [6:0] m_ac;
    bit m_id, m_two, m_disp, m_cur, m_blink, m_cg, m_ovr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: AC maps to a display position 0..79 and steps modulo 80.
    function automatic bit m_valid(logic [6:0] a, bit two);
        if (two) return (a & 7'h3F) < 7'd40;
        return a < 7'd80;
    endfunction

    function automatic int m_pos(logic [6:0] a, bit two);
        if (two) return (a >= 7'h40 ? 40 : 0) + int'(a & 7'h3F);
        return int'(a);
    endfunction

    function automatic logic [6:0] m_addr_of(int p, bit two);
        if (two && p >= 40) return 7'(64 + p - 40);
        return 7'(p);
    endfunction

    function automatic logic [6:0] m_next(logic [6:0] a, bit two, bit inc);
        int p;
        if (!m_valid(a, two)) return 7'd0;
        p = m_pos(a, two);
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return m_addr_of(p, two);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1; m_two = 0; m_cg = 0; m_ovr = 0;
        m_disp = 0; m_cur = 0; m_blink = 0;
    endtask

    task automatic m_write(bit rs, logic [7:0] d, bit bsy);
        if (bsy) m_ovr = 1;
        else if (rs) begin
            if (!m_cg) begin
                if (m_valid(m_ac, m_two)) m_mem[m_pos(m_ac, m_two)] = d;
                m_ac = m_next(m_ac, m_two, m_id);
            end
        end
        else if (d >= 8'h80) begin m_ac = d[6:0]; m_cg = 0; end
        else if (d >= 8'h40) m_cg = 1;
        else if (d >= 8'h20) m_two = d[3];
        else if (d >= 8'h10) begin
            if (!d[3]) m_ac = m_next(m_ac, m_two, d[2]);
        end
        else if (d >= 8'h08) {m_disp, m_cur, m_blink} = d[2:0];
        else if (d >= 8'h04) m_id = d[1];
        else if (d >= 8'h02) m_ac = 0;
        else if (d == 8'h01) begin
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
            m_ac = 0; m_id = 1;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic bus_write(bit rs, logic [7:0] d, bit bsy);
        @(negedge clk);
        bif.lcd_rs = rs; bif.lcd_rw = 0; bif.lcd_din = d;
        repeat (2) @(negedge clk);
        bif.lcd_en = 1;
        repeat (5) @(negedge clk);
        bif.lcd_en = 0;
        repeat (5) @(negedge clk);
        m_write(rs, d, bsy);
    endtask

    task automatic cmd(bit rs, logic [7:0] d, output int n);
        bus_write(rs, d, 0);
        wait_idle(n);
    endtask

    task automatic bus_read(bit rs, output logic [7:0] d);
        int n;
        @(negedge clk);
        bif.lcd_rs = rs; bif.lcd_rw = 1;
        repeat (2) @(negedge clk);
        bif.lcd_en = 1;
        repeat (5) @(negedge clk);
        d = bif.lcd_dout;
        chk("doe_hi", bif.lcd_doe, 1);
        bif.lcd_en = 0;
        repeat (5) @(negedge clk);
        chk("doe_lo", bif.lcd_doe, 0);
        bif.lcd_rw = 0;
        if (rs) m_ac = m_next(m_ac, m_two, m_id);
        wait_idle(n);
    endtask

    task automatic check_bf(string tag);
        logic [7:0] d;
        bus_read(0, d);
        chk(tag, d, {1'b0, m_ac});
    endtask

    task automatic check_mem(string tag);
        for (int i = 0; i < 80; i++) begin
            rd_addr = 7'(i);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", tag, i), rd_data, m_mem[i]);
        end
    endtask

    task automatic check_reset_outs(string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_modes"}, {disp_on, cursor_on, blink_on, two_line}, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_doe"}, bif.lcd_doe, 0);
        chk({tag, "_dout"}, bif.lcd_dout, 0);
        chk({tag, "_rd"}, rd_data, 0);
    endtask

    initial begin
        int n;
        logic [7:0] d, exp_d;
        logic [6:0] a;
        bit two;
        string ws;

        bif.lcd_en = 0; bif.lcd_rs = 0; bif.lcd_rw = 0; bif.lcd_din = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst = 0;
        wait_idle(n);
        chk("clear_len", n, CLEAR_CYC);
        check_mem("init");
        check_bf("bf_init");

        cmd(0, 8'h31, n);
        cmd(0, 8'h0C, n);
        chk("exec_len", n, BUSY_CYC - 2);
        cmd(0, 8'h06, n);
        cmd(0, 8'h01, n);
        chk("clr_len", n, CLEAR_CYC - 2);
        ws = "Waveshare";
        for (int i = 0; i < ws.len(); i++) cmd(1, ws[i], n);
        chk("disp_on", disp_on, m_disp);
        chk("cursor_on", cursor_on, m_cur);
        check_mem("ws");
        check_bf("bf_ws");

        cmd(0, 8'h38, n);
        cmd(0, 8'hA7, n);
        cmd(1, 8'h41, n);
        cmd(1, 8'h42, n);
        chk("two_line", two_line, m_two);
        check_mem("wrap2");
        check_bf("bf_wrap2");

        cmd(0, 8'h30, n);
        cmd(0, 8'h04, n);
        cmd(0, 8'h80, n);
        cmd(1, 8'h5A, n);
        check_mem("dec");
        check_bf("bf_dec");

        cmd(0, 8'hD0, n);
        bus_read(1, d);
        chk("rd_oor", d, 8'h20);
        check_bf("bf_snap");
        cmd(0, 8'hD0, n);
        cmd(1, 8'h77, n);
        check_bf("bf_snap2");
        check_mem("oor");

        cmd(0, 8'h0F, n);
        chk("modes_f", {disp_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
        cmd(0, 8'h0A, n);
        chk("modes_a", {disp_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
        cmd(0, 8'h85, n);
        cmd(0, 8'h14, n);
        check_bf("bf_shr");
        cmd(0, 8'h1C, n);
        check_bf("bf_dshift");
        cmd(0, 8'h10, n);
        cmd(0, 8'h10, n);
        check_bf("bf_shl");
        cmd(0, 8'h02, n);
        chk("home_len", n, CLEAR_CYC - 2);
        check_bf("bf_home");

        cmd(0, 8'h40, n);
        cmd(1, 8'h55, n);
        check_bf("bf_cg");
        cmd(0, 8'h80, n);
        check_mem("cg");

        for (int r = 0; r < 6; r++) begin
            two = 1'($urandom_range(0, 1));
            cmd(0, 8'h30 | {4'b0, two, 3'b0}, n);
            cmd(0, 8'h04 | 8'($urandom_range(0, 1) << 1), n);
            a = m_addr_of($urandom_range(0, 79), two);
            cmd(0, {1'b1, a}, n);
            for (int k = $urandom_range(1, 6); k > 0; k--)
                cmd(1, 8'($urandom), n);
            check_bf("bf_rand");
            cmd(0, {1'b1, a}, n);
            for (int k = 0; k < 3; k++) begin
                exp_d = m_valid(m_ac, m_two) ?
                        m_mem[m_pos(m_ac, m_two)] : 8'h20;
                bus_read(1, d);
                chk("rd_rand", d, exp_d);
            end
        end
        check_mem("rand");

        bus_write(0, 8'h0C, 0);
        bus_write(1, 8'hEE, 1);
        chk("overrun", overrun, m_ovr);
        wait_idle(n);
        check_mem("ovr");

        bus_write(0, 8'h01, 0);
        repeat (30) @(negedge clk);
        rst = 1;
        #1;
        m_reset();
        check_reset_outs("mid");
        repeat (2) @(negedge clk);
        rst = 0;
        wait_idle(n);
        chk("reclear_len", n, CLEAR_CYC);
        check_mem("reclear");
        check_bf("bf_reclear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
